sel_scan_ctrl: RTL and testbench



---
 rtl/sel_scan_pkg.sv | 14 +
 rtl/sel_scan_ctrl_if.sv | 26 ++
 rtl/sel_dwell_timer.sv | 29 ++
 rtl/sel_scan_ctrl.sv | 116 +++++++++++
 tb/tb_sel_scan_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sel_scan_pkg.sv
// Shared types and default widths for the select-decoder sweep/self-check block.
package sel_scan_pkg;

   localparam int unsigned SEL_W_DEF   = 2;
   localparam int unsigned DATA_W_DEF  = 4;
   localparam int unsigned DWELL_W_DEF = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StDone
   } state_e;

endpackage

// File: rtl/sel_scan_ctrl_if.sv
// Bus between the sweep controller (master) and its host plus the decoder under test (slave).
interface sel_scan_ctrl_if #(
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned DWELL_W = 4
);
   logic               start;
   logic [DWELL_W-1:0] dwell;
   logic [SEL_W-1:0]   sel;
   logic [DATA_W-1:0]  data;
   logic               busy;
   logic               done;
   logic               pass;
   logic [SEL_W:0]     err_count;
   logic [SEL_W-1:0]   first_err_sel;

   modport master (
      input  start, dwell, data,
      output sel, busy, done, pass, err_count, first_err_sel
   );

   modport slave (
      output start, dwell, data,
      input  sel, busy, done, pass, err_count, first_err_sel
   );
endinterface

// File: rtl/sel_dwell_timer.sv
// Loadable down-counter that stops at zero; sets how long each select code is held.
module sel_dwell_timer
   import sel_scan_pkg::*;
#(
   parameter int unsigned WIDTH = DWELL_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sel_scan_ctrl.sv
// Sweeps the decoder select through every code, compares the returned data against the
// zero-extended select and records mismatch count, first failing code and a pass flag.
module sel_scan_ctrl
   import sel_scan_pkg::*;
#(
   parameter int unsigned SEL_W   = SEL_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input logic             i_clk,
   input logic             i_reset,
   sel_scan_ctrl_if.master scan
);

   localparam logic [SEL_W-1:0] SelLast = '1;

   state_e             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_sel, w_sel_nxt;
   logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
   logic [SEL_W:0]     r_err, w_err_nxt;
   logic [SEL_W-1:0]   r_first, w_first_nxt;
   logic               r_pass, w_pass_nxt;

   logic               w_load, w_dec, w_zero, w_mismatch;
   logic [DWELL_W-1:0] w_load_val;

   sel_dwell_timer #(
      .WIDTH(DWELL_W)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_dec     (w_dec),
      .i_load_val(w_load_val),
      .o_zero    (w_zero)
   );

   assign w_mismatch = (scan.data != DATA_W'(r_sel));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_sel   <= '0;
         r_dwell <= '0;
         r_err   <= '0;
         r_first <= '0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_dwell <= w_dwell_nxt;
         r_err   <= w_err_nxt;
         r_first <= w_first_nxt;
         r_pass  <= w_pass_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_dwell_nxt = r_dwell;
      w_err_nxt   = r_err;
      w_first_nxt = r_first;
      w_pass_nxt  = r_pass;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_load_val  = r_dwell;

      unique case (r_state)
         StIdle: begin
            if (scan.start) begin
               w_state_nxt = StSettle;
               w_sel_nxt   = '0;
               w_dwell_nxt = scan.dwell;
               w_err_nxt   = '0;
               w_first_nxt = '0;
               w_pass_nxt  = 1'b0;
               w_load      = 1'b1;
               w_load_val  = scan.dwell;
            end
         end
         StSettle: begin
            if (!w_zero) begin
               w_dec = 1'b1;
            end else begin
               // Sample cycle: the counter has run out for the current code.
               if (w_mismatch) begin
                  w_err_nxt = r_err + (SEL_W+1)'(1);
                  if (r_err == '0) w_first_nxt = r_sel;
               end
               if (r_sel == SelLast) begin
                  w_state_nxt = StDone;
                  w_pass_nxt  = (w_err_nxt == '0);
               end else begin
                  w_sel_nxt = r_sel + SEL_W'(1);
                  w_load    = 1'b1;
               end
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign scan.sel           = r_sel;
   assign scan.busy          = (r_state != StIdle);
   assign scan.done          = (r_state == StDone);
   assign scan.pass          = r_pass;
   assign scan.err_count     = r_err;
   assign scan.first_err_sel = r_first;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Scoreboard bench: each accepted sweep pushes its hand-computed result; a monitor checks on done.
module tb_sel_scan_ctrl;

   localparam int unsigned SEL_W   = 2;
   localparam int unsigned DATA_W  = 4;
   localparam int unsigned DWELL_W = 4;

   typedef struct {
      int len;
      int err;
      int first;
      int pass;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic fault;
   always #5 clk = ~clk;

   sel_scan_ctrl_if #(.SEL_W(SEL_W), .DATA_W(DATA_W), .DWELL_W(DWELL_W)) scan ();

   sel_scan_ctrl #(
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W),
      .DWELL_W(DWELL_W)
   ) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .scan   (scan)
   );

   // Decoder model; the fault variant returns zero for codes 2 and 3.
   assign scan.data = (fault && (scan.sel >= 2)) ? '0 : DATA_W'(scan.sel);

   exp_t q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   busy_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         busy_cnt = 0;
      end else begin
         if (scan.busy) busy_cnt++;
         else busy_cnt = 0;
         if (scan.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = q.pop_front();
               chk("sweep_len", busy_cnt, mon_e.len);
               chk("err_count", int'(scan.err_count), mon_e.err);
               chk("first_err_sel", int'(scan.first_err_sel), mon_e.first);
               chk("pass", int'(scan.pass), mon_e.pass);
               chk("sel_at_done", int'(scan.sel), 3);
            end
         end
      end
   end

   task automatic start_sweep(input int dw, input bit f, input bit push, input int len,
                              input int err, input int first, input int pass);
      exp_t e;
      @(posedge clk);
      #1;
      fault      = f;
      scan.dwell = DWELL_W'(dw);
      scan.start = 1'b1;
      if (push) begin
         e.len = len; e.err = err; e.first = first; e.pass = pass;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      scan.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (scan.done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sel"}, int'(scan.sel), 0);
      chk({tag, "_busy"}, int'(scan.busy), 0);
      chk({tag, "_done"}, int'(scan.done), 0);
      chk({tag, "_pass"}, int'(scan.pass), 0);
      chk({tag, "_err"}, int'(scan.err_count), 0);
      chk({tag, "_first"}, int'(scan.first_err_sel), 0);
   endtask

   initial begin
      bit hit;
      reset      = 1'b1;
      fault      = 1'b0;
      scan.start = 1'b0;
      scan.dwell = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      reset = 1'b0;

      // Clean decoder, dwell 0: busy for 4 code cycles plus the done cycle.
      start_sweep(0, 0, 1, 5, 0, 0, 1);
      wait_done(50);

      // Clean decoder, dwell 3: 4 codes x 4 cycles + done.
      start_sweep(3, 0, 1, 17, 0, 0, 1);
      wait_done(100);

      // Faulty decoder on codes 2 and 3.
      start_sweep(1, 1, 1, 9, 2, 2, 0);
      wait_done(100);

      // Start pulses during SETTLE and DONE must be ignored.
      start_sweep(2, 0, 1, 13, 0, 0, 1);
      repeat (3) @(posedge clk);
      #1;
      scan.start = 1'b1;
      @(posedge clk);
      #1;
      scan.start = 1'b0;
      wait_done(100);
      scan.start = 1'b1;
      @(posedge clk);
      #1;
      scan.start = 1'b0;
      chk("idle_after_done", int'(scan.busy), 0);
      @(posedge clk);
      #1;
      chk("no_restart_from_done", int'(scan.busy), 0);
      chk("pass_hold", int'(scan.pass), 1);

      // Fault sweep then a fresh clean sweep: counters must be cleared on start.
      start_sweep(0, 1, 1, 5, 2, 2, 0);
      wait_done(50);
      chk("err_hold", int'(scan.err_count), 2);
      start_sweep(0, 0, 1, 5, 0, 0, 1);
      wait_done(50);

      // Reset mid-sweep while sel == 2.
      start_sweep(3, 1, 0, 0, 0, 0, 0);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (scan.sel == 2) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!hit) chk("sel2_timeout", 0, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("midrst");
      reset = 1'b0;
      start_sweep(0, 0, 1, 5, 0, 0, 1);
      wait_done(50);

      // Dwell input changed mid-sweep: latched value 3 still governs timing.
      start_sweep(3, 0, 1, 17, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      scan.dwell = '0;
      wait_done(100);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
